// File: rtl/slice_concat_pipe_if.sv
// Handshake bundle for slice_concat_pipe.
// The producer side carries i0/i1/swap and the consumer side carries o/occupancy.
interface slice_concat_pipe_if #(
  parameter int I0_LEFT  = 2,
  parameter int I0_RIGHT = -2,
  parameter int I1_LEFT  = -2,
  parameter int I1_RIGHT = 2,
  parameter int W        = 5,
  parameter int CW       = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [I0_LEFT:I0_RIGHT] i0;
  logic [I1_LEFT:I1_RIGHT] i1;
  logic                    swap;
  logic                    out_valid;
  logic                    out_ready;
  logic [W-1:0]            o;
  logic [CW-1:0]           occupancy;

  modport slave (
    input  in_valid, i0, i1, swap, out_ready,
    output in_ready, out_valid, o, occupancy
  );

  modport master (
    output in_valid, i0, i1, swap, out_ready,
    input  in_ready, out_valid, o, occupancy
  );
endinterface

// File: rtl/slice_concat_pipe.sv
// Elastic valid/ready pipeline that concatenates a slice of i0 with a slice of i1.
// A runtime swap bit selects the order of the two slices.
module slice_concat_pipe #(
  parameter int I0_LEFT  = 2,
  parameter int I0_RIGHT = -2,
  parameter int I1_LEFT  = -2,
  parameter int I1_RIGHT = 2,
  parameter int A_FIRST  = 2,
  parameter int A_LAST   = 0,
  parameter int B_FIRST  = -2,
  parameter int B_LAST   = -1,
  parameter int DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  slice_concat_pipe_if.slave bus
);
  localparam int WA    = (A_FIRST >= A_LAST) ? (A_FIRST - A_LAST + 1) : (A_LAST - A_FIRST + 1);
  localparam int WB    = (B_FIRST >= B_LAST) ? (B_FIRST - B_LAST + 1) : (B_LAST - B_FIRST + 1);
  localparam int W     = WA + WB;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int A_DIR = (A_FIRST >= A_LAST) ? -1 : 1;
  localparam int B_DIR = (B_FIRST >= B_LAST) ? -1 : 1;

  function automatic bit idx_in_range(int idx, int l, int r);
    if (l >= r) return (idx <= l) && (idx >= r);
    else        return (idx >= l) && (idx <= r);
  endfunction

  if (!idx_in_range(A_FIRST, I0_LEFT, I0_RIGHT) || !idx_in_range(A_LAST, I0_LEFT, I0_RIGHT)) begin : g_err_a_range
    $error("slice_concat_pipe: slice A lies outside the i0 range");
  end
  if (!idx_in_range(B_FIRST, I1_LEFT, I1_RIGHT) || !idx_in_range(B_LAST, I1_LEFT, I1_RIGHT)) begin : g_err_b_range
    $error("slice_concat_pipe: slice B lies outside the i1 range");
  end
  if ((A_FIRST != A_LAST) && ((A_FIRST > A_LAST) != (I0_LEFT > I0_RIGHT))) begin : g_err_a_dir
    $error("slice_concat_pipe: slice A runs against the i0 direction");
  end
  if ((B_FIRST != B_LAST) && ((B_FIRST > B_LAST) != (I1_LEFT > I1_RIGHT))) begin : g_err_b_dir
    $error("slice_concat_pipe: slice B runs against the i1 direction");
  end
  if ((DEPTH < 1) || (DEPTH > 8)) begin : g_err_depth
    $error("slice_concat_pipe: DEPTH must be within 1..8");
  end

  logic [WA-1:0]    slice_a_s;
  logic [WB-1:0]    slice_b_s;
  logic [W-1:0]     word_s;
  logic [DEPTH-1:0] adv_s;
  logic             in_ready_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [W-1:0]     d_q [DEPTH];
  logic [W-1:0]     d_d [DEPTH];
  logic [CW-1:0]    occ_q;
  logic [CW-1:0]    occ_d;

  // The FIRST index of each slice lands in its most significant bit.
  for (genvar k = 0; k < WA; k++) begin : g_slice_a
    assign slice_a_s[WA-1-k] = bus.i0[A_FIRST + k*A_DIR];
  end
  for (genvar k = 0; k < WB; k++) begin : g_slice_b
    assign slice_b_s[WB-1-k] = bus.i1[B_FIRST + k*B_DIR];
  end

  always_comb begin
    word_s = {W{1'b0}};
    if (bus.swap) begin
      word_s = {slice_b_s, slice_a_s};
    end else begin
      word_s = {slice_a_s, slice_b_s};
    end
  end

  // A stage may advance if any stage downstream of it is empty or the consumer is taking o.
  always_comb begin : p_advance
    logic run;
    adv_s          = {DEPTH{1'b0}};
    run            = bus.out_ready;
    adv_s[DEPTH-1] = run;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      run      = run | ~v_q[k+1];
      adv_s[k] = run;
    end
  end

  assign in_ready_s = ~rst & (~v_q[0] | adv_s[0]);
  assign in_fire_s  = bus.in_valid & in_ready_s;
  assign out_fire_s = v_q[DEPTH-1] & bus.out_ready;

  always_comb begin : p_next
    logic load;
    v_d    = v_q;
    d_d[0] = in_fire_s ? word_s : d_q[0];
    if (in_fire_s) begin
      v_d[0] = 1'b1;
    end else begin
      v_d[0] = v_q[0] & ~adv_s[0];
    end
    for (int k = 1; k < DEPTH; k++) begin
      load   = (~v_q[k] | adv_s[k]) & v_q[k-1];
      d_d[k] = load ? d_q[k-1] : d_q[k];
      if (load) begin
        v_d[k] = 1'b1;
      end else begin
        v_d[k] = v_q[k] & ~adv_s[k];
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({in_fire_s, out_fire_s})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= {DEPTH{1'b0}};
      occ_q <= {CW{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= {W{1'b0}};
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.o         = d_q[DEPTH-1];
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_slice_concat_pipe.sv
// Bench for slice_concat_pipe: default DEPTH=2 instance checked against a queue model,
// plus DEPTH=1 and DEPTH=8 (ascending i0) instances checked for latency and slice mapping.
module tb_slice_concat_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slice_concat_pipe_if #(.I0_LEFT(2), .I0_RIGHT(-2), .I1_LEFT(-2), .I1_RIGHT(2), .W(5), .CW(2)) ifa ();
  slice_concat_pipe #(.DEPTH(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  slice_concat_pipe_if #(.I0_LEFT(2), .I0_RIGHT(-2), .I1_LEFT(-2), .I1_RIGHT(2), .W(5), .CW(1)) ifb ();
  slice_concat_pipe #(.DEPTH(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  slice_concat_pipe_if #(.I0_LEFT(-3), .I0_RIGHT(4), .I1_LEFT(-2), .I1_RIGHT(2), .W(6), .CW(4)) ifc ();
  slice_concat_pipe #(.I0_LEFT(-3), .I0_RIGHT(4), .A_FIRST(-3), .A_LAST(0), .DEPTH(8))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  localparam int DA = 2;
  int errors = 0;
  int checks = 0;

  // Reference model: FIFO of accepted words with their age in edges since acceptance.
  logic [31:0] q_word [$];
  int          q_age  [$];
  logic        exp_in_ready, exp_out_valid, obs_in_ready, obs_out_valid;
  logic [4:0]  exp_o, obs_o;
  logic [1:0]  exp_occ, obs_occ;

  // Slice of a flat bus value declared [l:r], FIRST index ending up most significant.
  function automatic logic [31:0] slice_of(logic [31:0] flat, int l, int r, int f, int la);
    logic [31:0] acc;
    int cnt, step, idx, pos;
    acc  = 32'd0;
    cnt  = (f >= la) ? (f - la + 1) : (la - f + 1);
    step = (la >= f) ? 1 : -1;
    for (int n = 0; n < cnt; n++) begin
      idx = f + n * step;
      pos = (l >= r) ? (idx - r) : (r - idx);
      acc = (acc << 1) | {31'd0, flat[pos]};
    end
    return acc;
  endfunction

  function automatic logic [31:0] form_word(logic [31:0] f0, logic [31:0] f1, bit sw,
      int i0l, int i0r, int i1l, int i1r, int af, int al, int bf, int bl);
    logic [31:0] a, b;
    int wa, wb;
    wa = (af >= al) ? (af - al + 1) : (al - af + 1);
    wb = (bf >= bl) ? (bf - bl + 1) : (bl - bf + 1);
    a  = slice_of(f0, i0l, i0r, af, al);
    b  = slice_of(f1, i1l, i1r, bf, bl);
    return sw ? ((b << wa) | a) : ((a << wb) | b);
  endfunction

  // Drive one cycle on dut_a, record model expectations and DUT observations, advance the model.
  task automatic cycle_a(input bit iv, input logic [4:0] v0, input logic [4:0] v1, input bit sw, input bit ordy);
    bit in_f, out_f;
    ifa.in_valid = iv; ifa.i0 = v0; ifa.i1 = v1; ifa.swap = sw; ifa.out_ready = ordy;
    #2;
    exp_in_ready  = (rst == 1'b0) && ((q_word.size() < DA) || ordy);
    exp_out_valid = (q_word.size() > 0) && (q_age[0] >= DA - 1);
    exp_o         = exp_out_valid ? q_word[0][4:0] : 5'd0;
    exp_occ       = 2'(q_word.size());
    obs_in_ready  = ifa.in_ready;
    obs_out_valid = ifa.out_valid;
    obs_o         = ifa.o;
    obs_occ       = ifa.occupancy;
    in_f  = iv && exp_in_ready;
    out_f = exp_out_valid && ordy;
    @(posedge clk); #1;
    if (rst) begin
      q_word.delete(); q_age.delete();
    end else begin
      if (out_f) begin
        void'(q_word.pop_front()); void'(q_age.pop_front());
      end
      foreach (q_age[i]) q_age[i]++;
      if (in_f) begin
        q_word.push_back(form_word(32'(v0), 32'(v1), sw, 2, -2, -2, 2, 2, 0, -2, -1));
        q_age.push_back(0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle_a(1'b1, 5'h1f, 5'h1f, 1'b0, 1'b1);
    checks++;
    if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", obs_in_ready); end
    cycle_a(1'b1, 5'h1f, 5'h1f, 1'b0, 1'b1);
    checks++;
    if ({obs_in_ready, obs_out_valid, obs_occ, obs_o} !== 9'd0) begin
      errors++; $display("FAIL reset_state: got rdy=%b ov=%b occ=%0d o=%b want all 0", obs_in_ready, obs_out_valid, obs_occ, obs_o);
    end
    rst = 1'b0;
    cycle_a(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    checks++;
    if ({obs_in_ready, obs_out_valid, obs_occ, obs_o} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL reset_release: got rdy=%b ov=%b occ=%0d o=%b want rdy=1 rest 0", obs_in_ready, obs_out_valid, obs_occ, obs_o);
    end
  endtask

  task automatic test_format();
    logic [4:0] want [2];
    want[0] = 5'b10101;
    want[1] = 5'b01101;
    for (int s = 0; s < 2; s++) begin
      cycle_a(1'b1, 5'b10110, 5'b01101, s[0], 1'b1);
      cycle_a(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
      checks++;
      if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL format_early swap=%0d: out_valid got %b want 0", s, obs_out_valid); end
      cycle_a(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
      checks++;
      if ({obs_out_valid, obs_o} !== {1'b1, want[s]}) begin
        errors++; $display("FAIL format swap=%0d: got ov=%b o=%b want ov=1 o=%b", s, obs_out_valid, obs_o, want[s]);
      end
    end
  endtask

  task automatic test_streaming();
    for (int c = 0; c < 12; c++) begin
      cycle_a(c < 8, 5'($urandom), 5'($urandom), 1'($urandom), 1'b1);
      checks++;
      if ({obs_in_ready, obs_out_valid, obs_occ} !== {exp_in_ready, exp_out_valid, exp_occ}) begin
        errors++; $display("FAIL stream_ctl c=%0d: got rdy=%b ov=%b occ=%0d want rdy=%b ov=%b occ=%0d",
          c, obs_in_ready, obs_out_valid, obs_occ, exp_in_ready, exp_out_valid, exp_occ);
      end
      if (exp_out_valid) begin
        checks++;
        if (obs_o !== exp_o) begin errors++; $display("FAIL stream_data c=%0d: got %b want %b", c, obs_o, exp_o); end
      end
      if (c >= 2 && c < 8) begin
        checks++;
        if (obs_occ !== 2'd2) begin errors++; $display("FAIL stream_occ c=%0d: got %0d want 2", c, obs_occ); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] held;
    held = 5'd0;
    for (int c = 0; c < 10; c++) begin
      cycle_a(c < 5, 5'($urandom), 5'($urandom), 1'($urandom), c >= 5);
      if (c < 5) begin
        checks++;
        if (obs_in_ready !== (c < 2)) begin errors++; $display("FAIL bp_ready c=%0d: got %b want %b", c, obs_in_ready, (c < 2)); end
      end
      if (c == 2) held = obs_o;
      if (c > 2 && c < 5) begin
        checks++;
        if (obs_o !== held) begin errors++; $display("FAIL bp_hold c=%0d: got %b want %b", c, obs_o, held); end
      end
      if (exp_out_valid) begin
        checks++;
        if ({obs_out_valid, obs_o} !== {1'b1, exp_o}) begin
          errors++; $display("FAIL bp_data c=%0d: got ov=%b o=%b want ov=1 o=%b", c, obs_out_valid, obs_o, exp_o);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < 9; c++) begin
      cycle_a(c < 6, 5'($urandom), 5'($urandom), 1'($urandom), c >= 2);
      if (c >= 2 && c < 6) begin
        checks++;
        if ({obs_in_ready, obs_occ} !== {1'b1, 2'd2}) begin
          errors++; $display("FAIL simul c=%0d: got rdy=%b occ=%0d want rdy=1 occ=2", c, obs_in_ready, obs_occ);
        end
      end
      if (exp_out_valid) begin
        checks++;
        if (obs_o !== exp_o) begin errors++; $display("FAIL simul_data c=%0d: got %b want %b", c, obs_o, exp_o); end
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle_a(1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b0);
    cycle_a(1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b0);
    rst = 1'b1;
    cycle_a(1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b1);
    checks++;
    if ({obs_occ, obs_in_ready} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL midrst_pre: got occ=%0d rdy=%b want occ=2 rdy=0", obs_occ, obs_in_ready);
    end
    rst = 1'b0;
    cycle_a(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    checks++;
    if ({obs_out_valid, obs_o, obs_occ, obs_in_ready} !== {8'd0, 1'b1}) begin
      errors++; $display("FAIL midrst_post: got ov=%b o=%b occ=%0d rdy=%b want ov=0 o=0 occ=0 rdy=1", obs_out_valid, obs_o, obs_occ, obs_in_ready);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      cycle_a(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      checks++;
      if ({obs_in_ready, obs_out_valid, obs_occ} !== {exp_in_ready, exp_out_valid, exp_occ}) begin
        errors++; $display("FAIL rand_ctl c=%0d: got rdy=%b ov=%b occ=%0d want rdy=%b ov=%b occ=%0d",
          c, obs_in_ready, obs_out_valid, obs_occ, exp_in_ready, exp_out_valid, exp_occ);
      end
      if (exp_out_valid) begin
        checks++;
        if (obs_o !== exp_o) begin errors++; $display("FAIL rand_data c=%0d: got %b want %b", c, obs_o, exp_o); end
      end
    end
  endtask

  task automatic test_sweep();
    logic [4:0]  b0, b1, c1;
    logic [7:0]  c0;
    bit          sw;
    int          lat;
    logic [31:0] ref_w;
    ifa.in_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      b0 = 5'($urandom); b1 = 5'($urandom); sw = 1'($urandom);
      ifb.in_valid = 1'b1; ifb.i0 = b0; ifb.i1 = b1; ifb.swap = sw; ifb.out_ready = 1'b1;
      #2;
      checks++;
      if (ifb.in_ready !== 1'b1) begin errors++; $display("FAIL d1_ready n=%0d: got %b want 1", n, ifb.in_ready); end
      @(posedge clk); #1;
      ifb.in_valid = 1'b0;
      lat = 1;
      while (ifb.out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL d1_latency n=%0d: got %0d want 1", n, lat); end
      ref_w = form_word(32'(b0), 32'(b1), sw, 2, -2, -2, 2, 2, 0, -2, -1);
      checks++;
      if (ifb.o !== ref_w[4:0]) begin errors++; $display("FAIL d1_data n=%0d: got %b want %b", n, ifb.o, ref_w[4:0]); end
      @(posedge clk); #1;

      c0 = 8'($urandom); c1 = 5'($urandom); sw = 1'($urandom);
      ifc.in_valid = 1'b1; ifc.i0 = c0; ifc.i1 = c1; ifc.swap = sw; ifc.out_ready = 1'b1;
      #2;
      checks++;
      if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL d8_ready n=%0d: got %b want 1", n, ifc.in_ready); end
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
      lat = 1;
      while (ifc.out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat != 8) begin errors++; $display("FAIL d8_latency n=%0d: got %0d want 8", n, lat); end
      ref_w = form_word(32'(c0), 32'(c1), sw, -3, 4, -2, 2, -3, 0, -2, -1);
      checks++;
      if (ifc.o !== ref_w[5:0]) begin errors++; $display("FAIL d8_data n=%0d: got %b want %b", n, ifc.o, ref_w[5:0]); end
      @(posedge clk); #1;
      checks++;
      if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL d8_drain n=%0d: out_valid got %b want 0", n, ifc.out_valid); end
    end
  endtask

  initial begin
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.i0 = 5'd0; ifa.i1 = 5'd0; ifa.swap = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.i0 = 5'd0; ifb.i1 = 5'd0; ifb.swap = 1'b0; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.i0 = 8'd0; ifc.i1 = 5'd0; ifc.swap = 1'b0; ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_format();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
